tile_write_scheduler: RTL

- Single owner of the tile-map RAM write port (80x60 tiles, 13-bit index, 8-bit tile id).
- Serialises four requesters onto that port: map reload from map ROM, GAME OVER banner, pellet clear, and score digit redraw.
- Writes occur only in cycles where the display permits them.
- Sits between the Avalon register decode and the tile RAM; the VGA read side is untouched.

---
 rtl/tile_sched_pkg.sv | 39 +++
 rtl/tile_burst_ctr.sv | 45 ++++
 rtl/tile_write_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tile_sched_pkg.sv
`default_nettype none
// ============================================================================
// tile_sched_pkg : shared types and constants for the tile-map write scheduler
// Revision 1.0
// ============================================================================
package tile_sched_pkg;

    localparam int TILE_W      = 13;
    localparam int ID_W        = 8;
    localparam int ROW_TILES   = 80;
    localparam int BANNER_LEN  = 9;
    localparam int FONT_BASE   = 38;
    localparam int DIGIT_BASE  = 90;

    localparam logic [ID_W-1:0] BLANK_TILE   = 8'h25;
    localparam logic [4:0]      LETTER_SPACE = 5'd31;

    // G A M E _ O V E R as letter numbers (A = 0)
    localparam logic [4:0] BANNER_LETTERS [0:BANNER_LEN-1] = '{
        5'd6, 5'd0, 5'd12, 5'd4, LETTER_SPACE, 5'd14, 5'd21, 5'd4, 5'd17
    };

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RELOAD = 3'd1,
        ST_BANNER = 3'd2,
        ST_PELLET = 3'd3,
        ST_SCORE  = 3'd4
    } sched_state_e;

    // Two-row glyphs: top half at base+2n, bottom half one above it.
    function automatic logic [ID_W-1:0] glyph_id(input logic [ID_W-1:0] base,
                                                 input logic [4:0]      n,
                                                 input logic            bottom);
        return base + {2'b00, n, bottom};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_burst_ctr.sv
`default_nettype none
// ============================================================================
// tile_burst_ctr : burst pointer that advances only on issued writes
// Revision 1.0
// ============================================================================
module tile_burst_ctr
    import tile_sched_pkg::*;
#(
    parameter int W = TILE_W
)(
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         write_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] ptr_o,
    output logic         tc_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (write_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
    assign tc_o  = (ptr_q == term_i);

endmodule
`default_nettype wire

// File: rtl/tile_write_scheduler.sv
`default_nettype none
// ============================================================================
// tile_write_scheduler : sole owner of the tile RAM write port; serialises
// map reload, GAME OVER banner, pellet clear and score redraw bursts.
// Revision 1.0
// ============================================================================
module tile_write_scheduler
    import tile_sched_pkg::*;
#(
    parameter int MAP_TILES   = 4800,
    parameter int SCORE_TILE  = 761,
    parameter int BANNER_TILE = 3795
)(
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              wr_allow_i,
    input  logic              reload_req_i,
    input  logic              banner_req_i,
    input  logic              pel_valid_i,
    input  logic [TILE_W-1:0] pel_index_i,
    output logic              pel_ready_o,
    input  logic [15:0]       score_i,
    output logic [TILE_W-1:0] map_rom_addr_o,
    input  logic [ID_W-1:0]   map_rom_data_i,
    output logic              tw_en_o,
    output logic [TILE_W-1:0] tw_addr_o,
    output logic [ID_W-1:0]   tw_data_o,
    output logic              busy_o,
    output logic              reload_done_o
);

    localparam logic [TILE_W-1:0] RELOAD_LAST = TILE_W'(MAP_TILES - 1);
    localparam logic [TILE_W-1:0] MAP_LIMIT   = TILE_W'(MAP_TILES);
    localparam logic [TILE_W-1:0] BANNER_LAST = TILE_W'(2 * BANNER_LEN - 1);
    localparam logic [TILE_W-1:0] SCORE_LAST  = TILE_W'(7);
    localparam logic [TILE_W-1:0] BANNER_BASE = TILE_W'(BANNER_TILE);
    localparam logic [TILE_W-1:0] SCORE_BASE  = TILE_W'(SCORE_TILE);
    localparam logic [TILE_W-1:0] ROW_STEP    = TILE_W'(ROW_TILES);
    localparam logic [TILE_W-1:0] BANNER_COLS = TILE_W'(BANNER_LEN);

    sched_state_e state_q, state_d;

    logic              reload_p_q, reload_p_d;
    logic              banner_p_q, banner_p_d;
    logic              pel_p_q, pel_p_d;
    logic [TILE_W-1:0] pel_idx_q, pel_idx_d;
    logic              score_dirty_q, score_dirty_d;
    logic [15:0]       score_shadow_q, score_shadow_d;
    logic              prime_q, prime_d;
    logic              reload_done_q, reload_done_d;

    logic              wr_fire;
    logic [TILE_W-1:0] term;
    logic [TILE_W-1:0] ptr;
    logic              tc;
    logic              pel_in_range;
    logic              reload_finish;
    logic              sel_reload, sel_banner, sel_pel, sel_score;

    logic              banner_bottom;
    logic [3:0]        banner_col;
    logic [4:0]        banner_letter;
    logic              score_bottom;
    logic [3:0]        score_digit;

    tile_burst_ctr #(
        .W (TILE_W)
    ) u_burst_ctr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (state_q == ST_IDLE),
        .load_val_i ('0),
        .write_i    (wr_fire),
        .term_i     (term),
        .ptr_o      (ptr),
        .tc_o       (tc)
    );

    assign pel_in_range  = (pel_idx_q < MAP_LIMIT);
    assign reload_finish = (state_q == ST_RELOAD) && wr_fire && tc;

    assign sel_reload = (state_q == ST_IDLE) && (state_d == ST_RELOAD);
    assign sel_banner = (state_q == ST_IDLE) && (state_d == ST_BANNER);
    assign sel_pel    = (state_q == ST_IDLE) && (state_d == ST_PELLET);
    assign sel_score  = (state_q == ST_IDLE) && (state_d == ST_SCORE);

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed priority in IDLE, bursts run to completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (reload_p_q) begin
                    state_d = ST_RELOAD;
                end else if (banner_p_q) begin
                    state_d = ST_BANNER;
                end else if (pel_p_q) begin
                    state_d = ST_PELLET;
                end else if (score_dirty_q) begin
                    state_d = ST_SCORE;
                end
            end
            ST_RELOAD, ST_BANNER, ST_SCORE: begin
                if (wr_fire && tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PELLET: begin
                if (!pel_in_range || wr_allow_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: write strobe, address and tile id per burst position
    always_comb begin
        wr_fire        = 1'b0;
        term           = '0;
        tw_addr_o      = '0;
        tw_data_o      = '0;
        map_rom_addr_o = '0;

        banner_bottom = (ptr >= BANNER_COLS);
        banner_col    = banner_bottom ? 4'(ptr - BANNER_COLS) : ptr[3:0];
        banner_letter = (banner_col < 4'(BANNER_LEN)) ? BANNER_LETTERS[banner_col] : LETTER_SPACE;

        score_bottom = ptr[2];
        case (ptr[1:0])
            2'd0:    score_digit = score_shadow_q[15:12];
            2'd1:    score_digit = score_shadow_q[11:8];
            2'd2:    score_digit = score_shadow_q[7:4];
            default: score_digit = score_shadow_q[3:0];
        endcase

        case (state_q)
            ST_RELOAD: begin
                term           = RELOAD_LAST;
                wr_fire        = !prime_q && wr_allow_i;
                tw_addr_o      = ptr;
                tw_data_o      = map_rom_data_i;
                // Present the next address only once the current one is consumed
                map_rom_addr_o = wr_fire ? (ptr + 1'b1) : ptr;
            end
            ST_BANNER: begin
                term      = BANNER_LAST;
                wr_fire   = wr_allow_i;
                tw_addr_o = BANNER_BASE + (banner_bottom ? ROW_STEP : '0)
                          + {{(TILE_W-4){1'b0}}, banner_col};
                tw_data_o = (banner_letter == LETTER_SPACE) ? BLANK_TILE
                          : glyph_id(ID_W'(FONT_BASE), banner_letter, banner_bottom);
            end
            ST_PELLET: begin
                wr_fire   = wr_allow_i && pel_in_range;
                tw_addr_o = pel_idx_q;
                tw_data_o = BLANK_TILE;
            end
            ST_SCORE: begin
                term      = SCORE_LAST;
                wr_fire   = wr_allow_i;
                tw_addr_o = SCORE_BASE + (score_bottom ? ROW_STEP : '0)
                          + {{(TILE_W-2){1'b0}}, ptr[1:0]};
                tw_data_o = glyph_id(ID_W'(DIGIT_BASE), {1'b0, score_digit}, score_bottom);
            end
            default: begin
                wr_fire = 1'b0;
            end
        endcase
    end

    assign tw_en_o       = wr_fire;
    assign busy_o        = (state_q != ST_IDLE);
    assign reload_done_o = reload_done_q;
    assign pel_ready_o   = !pel_p_q && reset_n_i;

    // Pending latches: a new request wins over the clear of the same cycle
    always_comb begin
        reload_p_d     = (reload_p_q & ~sel_reload) | reload_req_i;
        banner_p_d     = (banner_p_q & ~sel_banner) | banner_req_i;
        pel_p_d        = pel_p_q & ~sel_pel & ~reload_finish;
        pel_idx_d      = pel_idx_q;
        if (pel_valid_i && pel_ready_o) begin
            pel_p_d   = 1'b1;
            pel_idx_d = pel_index_i;
        end
        // The select cycle still compares against the old shadow, so clear wins
        score_dirty_d  = sel_score ? 1'b0 : (score_dirty_q | (score_i != score_shadow_q));
        score_shadow_d = sel_score ? score_i : score_shadow_q;
        if (reload_finish) begin
            score_dirty_d = 1'b1;
        end
        reload_done_d  = reload_finish;
        prime_d        = sel_reload;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            reload_p_q     <= 1'b0;
            banner_p_q     <= 1'b0;
            pel_p_q        <= 1'b0;
            pel_idx_q      <= '0;
            score_dirty_q  <= 1'b1;
            score_shadow_q <= '0;
            prime_q        <= 1'b0;
            reload_done_q  <= 1'b0;
        end else begin
            reload_p_q     <= reload_p_d;
            banner_p_q     <= banner_p_d;
            pel_p_q        <= pel_p_d;
            pel_idx_q      <= pel_idx_d;
            score_dirty_q  <= score_dirty_d;
            score_shadow_q <= score_shadow_d;
            prime_q        <= prime_d;
            reload_done_q  <= reload_done_d;
        end
    end

endmodule
`default_nettype wire
